// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - two-byte instruction fetch from a byte-wide ROM with ready timeout; optional prefetch via INSTR_FETCH_PREFETCH_EN
module instr_fetch_unit #(
  parameter int ROM_TIMEOUT = 16,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_req,
  input  logic              fetch_flush,
  input  logic              instr_ack,
  output logic [7:0]        opcode1,
  output logic [7:0]        opcode2,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_data,
  input  logic              rom_rdy
);

  typedef enum logic [1:0] {IDLE, RD_OP1, RD_OP2, VALID} state_e;

  // Counter value on the last permitted wait cycle of a byte.
  localparam logic [7:0]        CNT_LAST = 8'(ROM_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        opcode1_q, opcode1_d;
  logic [7:0]        opcode2_q, opcode2_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] aligned;
  logic              rom_take;
  logic              timeout;
  logic              byte_done;
  logic [7:0]        byte_val;
  logic              start;

`ifdef INSTR_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {PF_NONE, PF_B0, PF_B1, PF_FULL} pf_state_e;

  pf_state_e         pf_state_q, pf_state_d;
  logic [7:0]        pf_buf0_q, pf_buf0_d;
  logic [7:0]        pf_buf1_q, pf_buf1_d;
  logic              pf_hit;
  logic              hit_take;
  logic              pf_step;
  logic              pf_launch;
  logic [ADDR_W-1:0] pf_base;
`endif

  // Bit 0 of the request address is always forced low.
  assign aligned   = fetch_addr & ~ADDR_ONE;
  assign rom_take  = rom_rd_q & rom_rdy;
  assign timeout   = rom_rd_q & ~rom_rdy & (cnt_q == CNT_LAST);
  assign byte_done = rom_take | timeout;
  assign byte_val  = rom_take ? rom_data : 8'h00;

`ifdef INSTR_FETCH_PREFETCH_EN
  assign pf_hit = (pf_state_q == PF_FULL) && (aligned == addr_q + ADDR_W'(2));
`endif

  // Registered state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      opcode1_q  <= 8'h00;
      opcode2_q  <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      cnt_q      <= 8'd0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_state_q <= PF_NONE;
      pf_buf0_q  <= 8'h00;
      pf_buf1_q  <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      opcode1_q  <= opcode1_d;
      opcode2_q  <= opcode2_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_state_q <= pf_state_d;
      pf_buf0_q  <= pf_buf0_d;
      pf_buf1_q  <= pf_buf1_d;
`endif
    end
  end

  // Next-state and output-register logic for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    opcode1_d  = opcode1_q;
    opcode2_d  = opcode2_q;
    valid_d    = valid_q;
    err_d      = err_q;
    rom_rd_d   = rom_rd_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    pf_state_d = pf_state_q;
    pf_buf0_d  = pf_buf0_q;
    pf_buf1_d  = pf_buf1_q;
    hit_take   = 1'b0;
    pf_step    = 1'b0;
    pf_launch  = 1'b0;
    pf_base    = addr_q;
`endif

    case (state_q)
      IDLE: begin
        if (fetch_flush || fetch_req) begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (!fetch_flush && pf_hit) hit_take = 1'b1;
          else start = 1'b1;
`else
          start = 1'b1;
`endif
        end
`ifdef INSTR_FETCH_PREFETCH_EN
        else begin
          pf_step = 1'b1;
        end
`endif
      end

      RD_OP1: begin
        if (fetch_flush) begin
          start = 1'b1;
        end else if (byte_done) begin
          opcode1_d  = byte_val;
          err_d      = err_q | timeout;
          rom_addr_d = addr_q + ADDR_ONE;
          cnt_d      = 8'd0;
          state_d    = RD_OP2;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RD_OP2: begin
        if (fetch_flush) begin
          start = 1'b1;
        end else if (byte_done) begin
          opcode2_d = byte_val;
          err_d     = err_q | timeout;
          rom_rd_d  = 1'b0;
          valid_d   = 1'b1;
          cnt_d     = 8'd0;
          state_d   = VALID;
`ifdef INSTR_FETCH_PREFETCH_EN
          pf_launch = 1'b1;
          pf_base   = addr_q;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      VALID: begin
        if (fetch_flush) begin
          start = 1'b1;
        end else if (instr_ack && fetch_req) begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (pf_hit) hit_take = 1'b1;
          else start = 1'b1;
`else
          start = 1'b1;
`endif
        end else begin
          if (instr_ack) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
`ifdef INSTR_FETCH_PREFETCH_EN
          pf_step = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef INSTR_FETCH_PREFETCH_EN
    // Background fill of the two-byte prefetch buffer while idle or valid.
    if (pf_step) begin
      case (pf_state_q)
        PF_B0: begin
          if (timeout) begin
            pf_state_d = PF_NONE;
            rom_rd_d   = 1'b0;
            cnt_d      = 8'd0;
          end else if (rom_take) begin
            pf_buf0_d  = rom_data;
            rom_addr_d = addr_q + ADDR_W'(3);
            cnt_d      = 8'd0;
            pf_state_d = PF_B1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PF_B1: begin
          if (timeout) begin
            pf_state_d = PF_NONE;
            rom_rd_d   = 1'b0;
            cnt_d      = 8'd0;
          end else if (rom_take) begin
            pf_buf1_d  = rom_data;
            rom_rd_d   = 1'b0;
            cnt_d      = 8'd0;
            pf_state_d = PF_FULL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    // A matching request is served straight from the buffer.
    if (hit_take) begin
      addr_d    = aligned;
      opcode1_d = pf_buf0_q;
      opcode2_d = pf_buf1_q;
      valid_d   = 1'b1;
      err_d     = 1'b0;
      state_d   = VALID;
      pf_launch = 1'b1;
      pf_base   = aligned;
    end
`endif

    // Any fresh fetch (request, flush or miss) discards in-progress work.
    if (start) begin
      addr_d     = aligned;
      state_d    = RD_OP1;
      rom_rd_d   = 1'b1;
      rom_addr_d = aligned;
      cnt_d      = 8'd0;
      err_d      = 1'b0;
      valid_d    = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_state_d = PF_NONE;
`endif
    end

`ifdef INSTR_FETCH_PREFETCH_EN
    if (pf_launch) begin
      pf_state_d = PF_B0;
      rom_rd_d   = 1'b1;
      rom_addr_d = pf_base + ADDR_W'(2);
      cnt_d      = 8'd0;
    end
`endif
  end

  assign opcode1     = opcode1_q;
  assign opcode2     = opcode2_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign rom_addr    = rom_addr_q;
  assign rom_rd      = rom_rd_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic [7:0] fetch_addr;
  logic       fetch_req;
  logic       fetch_flush;
  logic       instr_ack;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       instr_valid;
  logic       fetch_err;
  logic [7:0] rom_addr;
  logic       rom_rd;
  logic [7:0] rom_data;
  logic       rom_rdy;

  logic [7:0] rom_mem [256];
  int         rdy_delay;
  int         age;
  logic       prev_rd;
  logic [7:0] prev_addr;
  int         tests;
  int         fails;

  instr_fetch_unit #(.ROM_TIMEOUT(TO), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_addr  (fetch_addr),
    .fetch_req   (fetch_req),
    .fetch_flush (fetch_flush),
    .instr_ack   (instr_ack),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .rom_rdy     (rom_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  // ROM responder: asserts ready once a read has been held rdy_delay cycles
  // at one address; delay 0 ties ready high, a large delay never answers.
  initial begin
    age = 0; prev_rd = 1'b0; prev_addr = 8'h00; rom_rdy = 1'b0;
  end
  always @(negedge clk) begin
    if (rom_rd && prev_rd && rom_addr == prev_addr) age = age + 1;
    else age = 0;
    prev_rd   = rom_rd;
    prev_addr = rom_addr;
    rom_rdy   = (rdy_delay == 0) ? 1'b1 : (rom_rd && age >= rdy_delay);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each byte costs d+1 cycles if ROM answers before the timeout,
  // else exactly TO cycles and reads as zero; plus one cycle to start.
  task automatic do_fetch(input logic [7:0] a, input int d, input bit b2b, input string tag);
    logic [7:0] base;
    logic [7:0] base1;
    int per;
    int lat;
    bit late;
    base  = a & 8'hFE;
    base1 = base + 8'd1;
    late  = (d >= TO);
    per   = late ? TO : d + 1;
    if (!b2b && instr_valid === 1'b1) begin
      instr_ack = 1'b1; tick; instr_ack = 1'b0;
    end
    rdy_delay  = d;
    fetch_addr = a;
    fetch_req  = 1'b1;
    instr_ack  = b2b && instr_valid === 1'b1;
    tick;
    fetch_req = 1'b0;
    instr_ack = 1'b0;
    lat = 1;
    while (instr_valid !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    check({tag, " latency"}, lat, 1 + 2 * per);
    check({tag, " opcode1"}, opcode1, late ? 8'h00 : rom_mem[base]);
    check({tag, " opcode2"}, opcode2, late ? 8'h00 : rom_mem[base1]);
    check({tag, " fetch_err"}, fetch_err, late);
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom_range(1, 255));
    rom_mem[8'h10] = 8'h21;
    rom_mem[8'h11] = 8'h40;
    rdy_delay = 0;
    reset = 1'b0; fetch_addr = 8'h00; fetch_req = 1'b0; fetch_flush = 1'b0; instr_ack = 1'b0;
    tick; tick;
    check("reset instr_valid", instr_valid, 1'b0);
    check("reset rom_rd", rom_rd, 1'b0);
    check("reset rom_addr", rom_addr, 8'h00);
    check("reset opcodes", {opcode1, opcode2}, 16'h0000);
    check("reset fetch_err", fetch_err, 1'b0);
    reset = 1'b1;
    tick;

    // Basic fetch at 0x10 with ready tied high.
    fetch_addr = 8'h10; fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    check("basic rd op1", {rom_rd, rom_addr}, {1'b1, 8'h10});
    check("basic valid early", instr_valid, 1'b0);
    tick;
    check("basic rd op2", {rom_rd, rom_addr}, {1'b1, 8'h11});
    tick;
    check("basic valid", instr_valid, 1'b1);
    check("basic opcodes", {opcode1, opcode2}, 16'h2140);
    check("basic err", fetch_err, 1'b0);
    check("basic rd off", rom_rd, 1'b0);
    tick; tick; tick;
    check("hold valid", instr_valid, 1'b1);
    check("hold opcodes", {opcode1, opcode2}, 16'h2140);

    // Back-to-back: ack and new request in the same VALID cycle.
    instr_ack = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h12;
    tick;
    instr_ack = 1'b0; fetch_req = 1'b0;
    check("b2b no bubble", {instr_valid, rom_rd, rom_addr}, {1'b0, 1'b1, 8'h12});
    tick; tick;
    check("b2b valid", instr_valid, 1'b1);
    check("b2b opcodes", {opcode1, opcode2}, {rom_mem[8'h12], rom_mem[8'h13]});
    instr_ack = 1'b1;
    tick;
    instr_ack = 1'b0;
    check("ack to idle", {instr_valid, rom_rd}, 2'b00);
    instr_ack = 1'b1;
    tick;
    instr_ack = 1'b0;
    check("stray ack ignored", {instr_valid, rom_rd}, 2'b00);

    // Wait states and timeout boundaries.
    do_fetch(8'h50, 3, 1'b0, "wait3");
    do_fetch(8'h58, 4, 1'b0, "wait4");
    do_fetch(8'h60, 1000, 1'b0, "stuck");

    // Flush during RD_OP2 of a fetch at 0x20, redirect to 0xFF (wraps to 0xFE).
    instr_ack = 1'b1; tick; instr_ack = 1'b0;
    rdy_delay = 0; fetch_addr = 8'h20; fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    tick;
    check("flush pre op2", rom_addr, 8'h21);
    fetch_flush = 1'b1; fetch_addr = 8'hFF;
    tick;
    fetch_flush = 1'b0;
    check("flush priority", {instr_valid, rom_rd, rom_addr}, {1'b0, 1'b1, 8'hFE});
    tick;
    check("flush wrap op2", rom_addr, 8'hFF);
    tick;
    check("flush valid", instr_valid, 1'b1);
    check("flush opcodes", {opcode1, opcode2}, {rom_mem[8'hFE], rom_mem[8'hFF]});

    // Flush in IDLE acts as a request.
    instr_ack = 1'b1; tick; instr_ack = 1'b0;
    fetch_flush = 1'b1; fetch_addr = 8'h81;
    tick;
    fetch_flush = 1'b0;
    check("idle flush start", {rom_rd, rom_addr}, {1'b1, 8'h80});
    tick; tick;
    check("idle flush opcodes", {instr_valid, opcode1, opcode2}, {1'b1, rom_mem[8'h80], rom_mem[8'h81]});

    // Asynchronous reset while waiting in RD_OP1.
    instr_ack = 1'b1; tick; instr_ack = 1'b0;
    rdy_delay = 1000; fetch_addr = 8'h44; fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    check("pre reset rd", rom_rd, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async reset outputs", {rom_rd, instr_valid, fetch_err, rom_addr, opcode1, opcode2}, 27'h0);
    tick;
    reset = 1'b1;
    rdy_delay = 0;
    tick; tick;
    check("post reset idle", {rom_rd, instr_valid}, 2'b00);

    // Randomized fetches, alternating idle and back-to-back issue.
    for (int i = 0; i < 24; i++) begin
      int d;
      d = $urandom_range(0, 6);
      if (d == 6) d = 1000;
      do_fetch(8'($urandom), d, (i % 2) == 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
